// File: rtl/weight_loader_wq_weight_mmap_m_axi_burst_split.sv
// Splits one linear read request into AXI4 AR bursts. Each burst holds at most
// MAX_BURST beats, stays inside a 4 KB page, and is issued only while outstanding-burst credit remains.
module weight_loader_wq_weight_mmap_m_axi_burst_split #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_BYTES_LOG2 = 6,
    parameter int LEN_WIDTH       = 32,
    parameter int MAX_BURST       = 256,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] ar_addr,
    output logic [7:0]            ar_len,
    output logic                  ar_valid,
    input  logic                  ar_ready,
    input  logic                  burst_done,
    output logic                  busy
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = (LEN_WIDTH > 14) ? LEN_WIDTH : 14;
    localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUTSTANDING);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = {ADDR_WIDTH{1'b1}} << DATA_BYTES_LOG2;

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    state_t                state_q;
    logic                  req_ready_q;
    logic                  ar_valid_q;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [7:0]            ar_len_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [OW-1:0]         outstanding_q;

    logic                  ar_fire;
    logic                  done_eff;
    logic                  accept;
    logic                  credit_ok;
    logic [OW-1:0]         outstanding_d;
    logic [8:0]            cur_beats;
    logic [ADDR_WIDTH-1:0] next_addr_d;
    logic [ADDR_WIDTH-1:0] req_addr_aligned;
    logic [LEN_WIDTH-1:0]  remaining_d;

    // Beats in the burst starting at page offset page_off: bounded by the
    // remaining count, MAX_BURST, and the distance to the next 4 KB boundary.
    function automatic logic [8:0] burst_beats(input logic [11:0] page_off,
                                               input logic [LEN_WIDTH-1:0] rem);
        logic [12:0]   page_bytes;
        logic [SW-1:0] page_beats;
        logic [SW-1:0] size;
        page_bytes = 13'd4096 - {1'b0, page_off};
        page_beats = SW'(page_bytes >> DATA_BYTES_LOG2);
        size       = SW'(MAX_BURST);
        if (page_beats < size) begin
            size = page_beats;
        end
        if (SW'(rem) < size) begin
            size = SW'(rem);
        end
        return 9'(size);
    endfunction

    always_comb begin
        ar_fire          = ar_valid_q & ar_ready;
        done_eff         = burst_done & (outstanding_q != '0);
        accept           = req_ready_q & req_valid;
        req_addr_aligned = req_addr & BEAT_MASK;

        outstanding_d = outstanding_q;
        if (ar_fire && !done_eff) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!ar_fire && done_eff) begin
            outstanding_d = outstanding_q - OW'(1);
        end
        credit_ok = (outstanding_d < MAX_OUT_C);

        // The burst on ar_* is ar_len_q+1 beats; the next one starts right after it.
        cur_beats   = {1'b0, ar_len_q} + 9'd1;
        next_addr_d = ar_addr_q + (ADDR_WIDTH'(cur_beats) << DATA_BYTES_LOG2);
        remaining_d = remaining_q - LEN_WIDTH'(cur_beats);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            ar_valid_q    <= 1'b0;
            ar_addr_q     <= '0;
            ar_len_q      <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            case (state_q)
                IDLE: begin
                    ar_valid_q <= 1'b0;
                    if (accept && (req_len != '0)) begin
                        state_q     <= SPLIT;
                        req_ready_q <= 1'b0;
                        ar_valid_q  <= credit_ok;
                        ar_addr_q   <= req_addr_aligned;
                        ar_len_q    <= 8'(burst_beats(req_addr_aligned[11:0], req_len) - 9'd1);
                        remaining_q <= req_len;
                        busy_q      <= 1'b1;
                    end else begin
                        req_ready_q <= 1'b1;
                        busy_q      <= (outstanding_d != '0);
                    end
                end
                SPLIT: begin
                    if (ar_fire && (remaining_d == '0)) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        ar_valid_q  <= 1'b0;
                        busy_q      <= (outstanding_d != '0);
                    end else begin
                        if (ar_fire) begin
                            ar_addr_q   <= next_addr_d;
                            ar_len_q    <= 8'(burst_beats(next_addr_d[11:0], remaining_d) - 9'd1);
                            remaining_q <= remaining_d;
                        end
                        // Without a handshake the count cannot grow, so a raised valid stays raised.
                        ar_valid_q <= credit_ok;
                        busy_q     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign ar_valid  = ar_valid_q;
    assign ar_addr   = ar_addr_q;
    assign ar_len    = ar_len_q;
    assign busy      = busy_q;

endmodule
